cpu_addr_unit: RTL and testbench

- Datapath companion downstream of the control FSM (cpu_ctrl).
- Consumes its registered `state` and `opcode` outputs and owns the program counter (PC), stack pointer (SP) and a call-target latch (TMP).
- Drives the 8-bit memory address, write strobe and write data for every fetch, jump, call, return, push and pop.
- Enforces stack bounds and halt.

---
 rtl/cpu_addr_unit.sv | 112 +++++++++++
 tb/tb_cpu_addr_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/cpu_addr_unit.sv
// Address/stack datapath behind the control FSM: owns PC, SP and the call-target latch,
// and drives the registered memory address, write strobe and write data.
module cpu_addr_unit #(
  parameter logic [7:0] PC_RESET    = 8'h00,
  parameter logic [7:0] SP_RESET    = 8'hFF,
  parameter logic [7:0] STACK_LIMIT = 8'h80
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] state,
  input  logic [7:0] opcode,
  input  logic [7:0] bus_in,
  input  logic [7:0] reg_data,
  output logic [7:0] mem_addr,
  output logic       mem_we,
  output logic [7:0] mem_wdata,
  output logic [7:0] pc,
  output logic [7:0] sp,
  output logic       halted,
  output logic       stack_ovf,
  output logic       stack_unf
);

  localparam int unsigned W = 8;

  localparam logic [W-1:0] ST_FETCH_PC  = 8'h01;
  localparam logic [W-1:0] ST_HALT      = 8'h03;
  localparam logic [W-1:0] ST_JUMP      = 8'h04;
  localparam logic [W-1:0] ST_FETCH_SP  = 8'h0C;
  localparam logic [W-1:0] ST_PC_STORE  = 8'h0D;
  localparam logic [W-1:0] ST_TMP_JUMP  = 8'h0E;
  localparam logic [W-1:0] ST_RET       = 8'h0F;
  localparam logic [W-1:0] ST_INC_SP    = 8'h10;
  localparam logic [W-1:0] ST_REG_STORE = 8'h13;
  localparam logic [W-1:0] ST_SET_REG   = 8'h14;

  localparam logic [W-1:0] OP_CALL = 8'h01;
  localparam logic [W-1:0] OP_RET  = 8'h02;
  localparam logic [W-1:0] OP_PUSH = 8'h20;
  localparam logic [W-1:0] OP_POP  = 8'h28;

  logic [W-1:0] tmp;
  logic         inhibit;
  logic         push_like;
  logic         pop_like;

  // CALL pushes its return address exactly like PUSH; RET reads the stack like POP.
  assign push_like = (opcode == OP_PUSH) || (opcode == OP_CALL);
  assign pop_like  = (opcode == OP_POP)  || (opcode == OP_RET);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc        <= PC_RESET;
      sp        <= SP_RESET;
      tmp       <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      halted    <= 1'b0;
      stack_ovf <= 1'b0;
      stack_unf <= 1'b0;
      inhibit   <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (!halted) begin
        case (state)
          ST_FETCH_PC: begin
            mem_addr <= pc;
            pc       <= W'(pc + W'(1));
          end
          ST_JUMP: pc <= bus_in;
          ST_SET_REG: begin
            if (opcode == OP_CALL) tmp <= bus_in;
          end
          ST_FETCH_SP: begin
            if (push_like) begin
              mem_addr <= sp;
              // A push below the limit still presents the address but suppresses the write.
              if (sp >= STACK_LIMIT) begin
                sp      <= W'(sp - W'(1));
                inhibit <= 1'b0;
              end else begin
                stack_ovf <= 1'b1;
                inhibit   <= 1'b1;
              end
            end else if (pop_like) begin
              mem_addr <= sp;
            end
          end
          ST_INC_SP: begin
            if (sp != SP_RESET) sp <= W'(sp + W'(1));
            else                stack_unf <= 1'b1;
          end
          ST_REG_STORE: begin
            mem_wdata <= reg_data;
            mem_we    <= !inhibit;
          end
          ST_PC_STORE: begin
            mem_wdata <= pc;
            mem_we    <= !inhibit;
            pc        <= tmp;
          end
          ST_TMP_JUMP: pc <= tmp;
          ST_RET:      pc <= bus_in;
          ST_HALT:     halted <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_addr_unit.sv
// Directed scoreboard bench for cpu_addr_unit: default-limit instance plus a STACK_LIMIT=FE instance.
module tb_cpu_addr_unit;

  typedef struct packed {
    logic [7:0] addr;
    logic       we;
    logic [7:0] wdata;
    logic [7:0] pc;
    logic [7:0] sp;
    logic       halted;
    logic       ovf;
    logic       unf;
  } obs_t;

  localparam logic [7:0] NEXT = 8'h00, FETCH_PC = 8'h01, HALT = 8'h03, JUMP = 8'h04,
                         FETCH_SP = 8'h0C, PC_STORE = 8'h0D, TMP_JUMP = 8'h0E, RET = 8'h0F,
                         INC_SP = 8'h10, REG_STORE = 8'h13, SET_REG = 8'h14;
  localparam logic [7:0] OP_CALL = 8'h01, OP_RET = 8'h02, OP_PUSH = 8'h20, OP_POP = 8'h28;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] state, opcode, bus_in, reg_data;

  logic [7:0] mem_addr, mem_wdata, pc, sp;
  logic       mem_we, halted, stack_ovf, stack_unf;
  logic [7:0] l_mem_addr, l_mem_wdata, l_pc, l_sp;
  logic       l_mem_we, l_halted, l_stack_ovf, l_stack_unf;

  int tests = 0;
  int fails = 0;
  obs_t  exp_q[$];
  string tag_q[$];

  cpu_addr_unit dut (
    .clk(clk), .reset_n(reset_n), .state(state), .opcode(opcode), .bus_in(bus_in),
    .reg_data(reg_data), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .pc(pc), .sp(sp), .halted(halted), .stack_ovf(stack_ovf), .stack_unf(stack_unf)
  );

  cpu_addr_unit #(.STACK_LIMIT(8'hFE)) dut_lim (
    .clk(clk), .reset_n(reset_n), .state(state), .opcode(opcode), .bus_in(bus_in),
    .reg_data(reg_data), .mem_addr(l_mem_addr), .mem_we(l_mem_we), .mem_wdata(l_mem_wdata),
    .pc(l_pc), .sp(l_sp), .halted(l_halted), .stack_ovf(l_stack_ovf), .stack_unf(l_stack_unf)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input logic [7:0] a, input logic w, input logic [7:0] d,
                              input logic [7:0] p, input logic [7:0] s,
                              input logic h, input logic o, input logic u);
    mk = '{addr: a, we: w, wdata: d, pc: p, sp: s, halted: h, ovf: o, unf: u};
  endfunction

  function automatic obs_t sample(input bit lim);
    if (lim) sample = mk(l_mem_addr, l_mem_we, l_mem_wdata, l_pc, l_sp, l_halted, l_stack_ovf, l_stack_unf);
    else     sample = mk(mem_addr, mem_we, mem_wdata, pc, sp, halted, stack_ovf, stack_unf);
  endfunction

  task automatic check(input bit lim);
    obs_t  o, e;
    string t;
    o = sample(lim);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed addr=%h we=%b wdata=%h pc=%h sp=%h h=%b ovf=%b unf=%b, expected addr=%h we=%b wdata=%h pc=%h sp=%h h=%b ovf=%b unf=%b",
             t, o.addr, o.we, o.wdata, o.pc, o.sp, o.halted, o.ovf, o.unf,
             e.addr, e.we, e.wdata, e.pc, e.sp, e.halted, e.ovf, e.unf);
    end
  endtask

  // Drive one state code for one clock edge, then compare just after that edge.
  task automatic step(input logic [7:0] st, input logic [7:0] op, input logic [7:0] bin,
                      input logic [7:0] rd, input obs_t e, input string tag, input bit lim);
    @(negedge clk);
    state = st; opcode = op; bus_in = bin; reg_data = rd;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    check(lim);
  endtask

  // Assert reset between edges and check outputs before any clock edge occurs.
  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    state = NEXT; opcode = 8'h00; bus_in = 8'h00; reg_data = 8'h00;
    exp_q.push_back(mk(8'h00, 1'b0, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0));
    tag_q.push_back(tag);
    #1;
    check(1'b0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b1;
    state = NEXT; opcode = 8'h00; bus_in = 8'h00; reg_data = 8'h00;
    #2;
    do_reset("reset");

    step(FETCH_PC, 8'h00, 8'h00, 8'h00, mk(8'h00, 0, 8'h00, 8'h01, 8'hFF, 0, 0, 0), "fetch0", 0);
    step(FETCH_PC, 8'h00, 8'h00, 8'h00, mk(8'h01, 0, 8'h00, 8'h02, 8'hFF, 0, 0, 0), "fetch1", 0);
    step(FETCH_PC, 8'h00, 8'h00, 8'h00, mk(8'h02, 0, 8'h00, 8'h03, 8'hFF, 0, 0, 0), "fetch2", 0);
    step(JUMP,     8'h00, 8'hFF, 8'h00, mk(8'h02, 0, 8'h00, 8'hFF, 8'hFF, 0, 0, 0), "jump_ff", 0);
    step(FETCH_PC, 8'h00, 8'h00, 8'h00, mk(8'hFF, 0, 8'h00, 8'h00, 8'hFF, 0, 0, 0), "pc_wrap", 0);

    step(JUMP,     8'h00, 8'h10, 8'h00, mk(8'hFF, 0, 8'h00, 8'h10, 8'hFF, 0, 0, 0), "jmp_pre", 0);
    step(FETCH_PC, 8'h00, 8'h00, 8'h00, mk(8'h10, 0, 8'h00, 8'h11, 8'hFF, 0, 0, 0), "jmp_fetch", 0);
    step(JUMP,     8'h00, 8'h42, 8'h00, mk(8'h10, 0, 8'h00, 8'h42, 8'hFF, 0, 0, 0), "jmp_42", 0);

    step(JUMP,     8'h00,   8'h20, 8'h00, mk(8'h10, 0, 8'h00, 8'h20, 8'hFF, 0, 0, 0), "call_pre", 0);
    step(FETCH_PC, OP_CALL, 8'h00, 8'h00, mk(8'h20, 0, 8'h00, 8'h21, 8'hFF, 0, 0, 0), "call_fetch", 0);
    step(SET_REG,  OP_CALL, 8'h60, 8'h00, mk(8'h20, 0, 8'h00, 8'h21, 8'hFF, 0, 0, 0), "call_setreg", 0);
    step(FETCH_SP, OP_CALL, 8'h00, 8'h00, mk(8'hFF, 0, 8'h00, 8'h21, 8'hFE, 0, 0, 0), "call_fetchsp", 0);
    step(PC_STORE, OP_CALL, 8'h00, 8'h00, mk(8'hFF, 1, 8'h21, 8'h60, 8'hFE, 0, 0, 0), "call_store", 0);
    step(NEXT,     8'h00,   8'h00, 8'h00, mk(8'hFF, 0, 8'h21, 8'h60, 8'hFE, 0, 0, 0), "we_pulse_end", 0);

    step(INC_SP,   OP_RET, 8'h00, 8'h00, mk(8'hFF, 0, 8'h21, 8'h60, 8'hFF, 0, 0, 0), "ret_incsp", 0);
    step(FETCH_SP, OP_RET, 8'h00, 8'h00, mk(8'hFF, 0, 8'h21, 8'h60, 8'hFF, 0, 0, 0), "ret_fetchsp", 0);
    step(RET,      OP_RET, 8'h21, 8'h00, mk(8'hFF, 0, 8'h21, 8'h21, 8'hFF, 0, 0, 0), "ret_pc", 0);

    step(FETCH_SP,  OP_PUSH, 8'h00, 8'h00, mk(8'hFF, 0, 8'h21, 8'h21, 8'hFE, 0, 0, 0), "push_fetchsp", 0);
    step(REG_STORE, OP_PUSH, 8'h00, 8'hAB, mk(8'hFF, 1, 8'hAB, 8'h21, 8'hFE, 0, 0, 0), "push_store", 0);
    step(NEXT,      8'h00,   8'h00, 8'h00, mk(8'hFF, 0, 8'hAB, 8'h21, 8'hFE, 0, 0, 0), "push_we_end", 0);
    step(INC_SP,    OP_POP,  8'h00, 8'h00, mk(8'hFF, 0, 8'hAB, 8'h21, 8'hFF, 0, 0, 0), "pop_incsp", 0);
    step(FETCH_SP,  OP_POP,  8'h00, 8'h00, mk(8'hFF, 0, 8'hAB, 8'h21, 8'hFF, 0, 0, 0), "pop_fetchsp", 0);

    // SET_REG without CALL must leave the call target at 60.
    step(SET_REG,  OP_PUSH, 8'h77, 8'h00, mk(8'hFF, 0, 8'hAB, 8'h21, 8'hFF, 0, 0, 0), "setreg_noncall", 0);
    step(TMP_JUMP, 8'h00,   8'h00, 8'h00, mk(8'hFF, 0, 8'hAB, 8'h60, 8'hFF, 0, 0, 0), "tmp_jump", 0);

    do_reset("reset_unf");
    step(INC_SP,    OP_POP,  8'h00, 8'h00, mk(8'h00, 0, 8'h00, 8'h00, 8'hFF, 0, 0, 1), "unf_incsp", 0);
    step(FETCH_SP,  OP_POP,  8'h00, 8'h00, mk(8'hFF, 0, 8'h00, 8'h00, 8'hFF, 0, 0, 1), "unf_fetchsp", 0);
    step(FETCH_SP,  OP_PUSH, 8'h00, 8'h00, mk(8'hFF, 0, 8'h00, 8'h00, 8'hFE, 0, 0, 1), "unf_push_sp", 0);
    step(REG_STORE, OP_PUSH, 8'h00, 8'h5A, mk(8'hFF, 1, 8'h5A, 8'h00, 8'hFE, 0, 0, 1), "unf_push_wr", 0);

    step(JUMP,      8'h00,   8'h33, 8'h00, mk(8'hFF, 0, 8'h5A, 8'h33, 8'hFE, 0, 0, 1), "halt_pre", 0);
    step(HALT,      8'h00,   8'h00, 8'h00, mk(8'hFF, 0, 8'h5A, 8'h33, 8'hFE, 1, 0, 1), "halt", 0);
    step(FETCH_PC,  8'h00,   8'h00, 8'h00, mk(8'hFF, 0, 8'h5A, 8'h33, 8'hFE, 1, 0, 1), "halt_fetch", 0);
    step(JUMP,      8'h00,   8'h99, 8'h00, mk(8'hFF, 0, 8'h5A, 8'h33, 8'hFE, 1, 0, 1), "halt_jump", 0);
    step(FETCH_SP,  OP_PUSH, 8'h00, 8'h00, mk(8'hFF, 0, 8'h5A, 8'h33, 8'hFE, 1, 0, 1), "halt_fetchsp", 0);
    step(REG_STORE, OP_PUSH, 8'h00, 8'hC3, mk(8'hFF, 0, 8'h5A, 8'h33, 8'hFE, 1, 0, 1), "halt_store", 0);

    do_reset("reset_halt");
    step(FETCH_PC, OP_CALL, 8'h00, 8'h00, mk(8'h00, 0, 8'h00, 8'h01, 8'hFF, 0, 0, 0), "mid_fetch", 0);
    step(SET_REG,  OP_CALL, 8'h60, 8'h00, mk(8'h00, 0, 8'h00, 8'h01, 8'hFF, 0, 0, 0), "mid_setreg", 0);
    step(FETCH_SP, OP_CALL, 8'h00, 8'h00, mk(8'hFF, 0, 8'h00, 8'h01, 8'hFE, 0, 0, 0), "mid_fetchsp", 0);
    do_reset("reset_mid_call");

    step(FETCH_SP,  OP_PUSH, 8'h00, 8'h00, mk(8'hFF, 0, 8'h00, 8'h00, 8'hFE, 0, 0, 0), "lim_push1_sp", 1);
    step(REG_STORE, OP_PUSH, 8'h00, 8'h11, mk(8'hFF, 1, 8'h11, 8'h00, 8'hFE, 0, 0, 0), "lim_push1_wr", 1);
    step(FETCH_SP,  OP_PUSH, 8'h00, 8'h00, mk(8'hFE, 0, 8'h11, 8'h00, 8'hFD, 0, 0, 0), "lim_push2_sp", 1);
    step(REG_STORE, OP_PUSH, 8'h00, 8'h22, mk(8'hFE, 1, 8'h22, 8'h00, 8'hFD, 0, 0, 0), "lim_push2_wr", 1);
    step(FETCH_SP,  OP_PUSH, 8'h00, 8'h00, mk(8'hFD, 0, 8'h22, 8'h00, 8'hFD, 0, 1, 0), "lim_push3_ovf", 1);
    step(REG_STORE, OP_PUSH, 8'h00, 8'h33, mk(8'hFD, 0, 8'h33, 8'h00, 8'hFD, 0, 1, 0), "lim_push3_nowr", 1);
    step(INC_SP,    OP_POP,  8'h00, 8'h00, mk(8'hFD, 0, 8'h33, 8'h00, 8'hFE, 0, 1, 0), "lim_pop_after", 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
